asic_iopoc_ctrl: RTL



---
 rtl/asic_iopoc_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/asic_iopoc_ctrl.sv
// asic_iopoc_ctrl -- padring power-on-control sequencer.
//
// Holds the pads in their safe state (poc=1) until the IO supply has been
// continuously good for DEBOUNCE cycles and a further HOLD cycles have
// elapsed. It then releases poc, waits SETTLE cycles and enables the IO.
// Power-down reverses this: io_en drops at once, and poc re-asserts SETTLE
// cycles later. Loss of supply while powered forces FAULT, which is left
// only by dropping en.
//
// Ports
//   clk        core clock
//   reset      synchronous, active-high reset
//   en         power-up request level (0 = power down)
//   supply_ok  asynchronous IO-supply-good from the analog detector
//   poc        power-on-control to padring (1 = pads safe/tristated)
//   io_en      padring IO enable (ACTIVE only)
//   ready      padring usable (ACTIVE only)
//   fault      supply-loss flag, held for the whole FAULT state
//   state      current FSM state code
module asic_iopoc_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 16,
  parameter int HOLD        = 64,
  parameter int SETTLE      = 8,
  parameter int CW          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       supply_ok,
  output logic       poc,
  output logic       io_en,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state
);

  localparam logic [2:0] S_OFF     = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_HOLD    = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_ACTIVE  = 3'd4;
  localparam logic [2:0] S_DOWN    = 3'd5;
  localparam logic [2:0] S_FAULT   = 3'd6;

  // Terminal counts: a window of N cycles ends when the counter reads N-1.
  localparam logic [CW-1:0] DEB_LAST    = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   supply_s;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;
  logic [2:0]             nxt;

  // supply_ok is shifted in at bit 0; the oldest stage is the qualified view.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], supply_ok};
  end

  assign supply_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt + CW'(1);
    case (state)
      S_OFF: begin
        cnt_nxt = '0;
        if (en) nxt = S_WAIT;
      end
      S_WAIT: begin
        // Debounce: any low synchronized sample restarts the window.
        if (!en)                  nxt     = S_OFF;
        else if (!supply_s)       cnt_nxt = '0;
        else if (cnt == DEB_LAST) nxt     = S_HOLD;
      end
      S_HOLD: begin
        if (!supply_s)             nxt = S_FAULT;
        else if (!en)              nxt = S_OFF;
        else if (cnt == HOLD_LAST) nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (!supply_s)               nxt = S_FAULT;
        else if (!en)                nxt = S_OFF;
        else if (cnt == SETTLE_LAST) nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        cnt_nxt = '0;
        if (!supply_s) nxt = S_FAULT;
        else if (!en)  nxt = S_DOWN;
      end
      S_DOWN: begin
        // en is deliberately ignored here: power-up restarts from OFF.
        if (!supply_s)               nxt = S_FAULT;
        else if (cnt == SETTLE_LAST) nxt = S_OFF;
      end
      S_FAULT: begin
        cnt_nxt = '0;
        if (!en) nxt = S_OFF;
      end
      default: begin
        cnt_nxt = '0;
        nxt     = S_OFF;
      end
    endcase
    if (nxt != state) cnt_nxt = '0;
  end

  // Outputs are decoded from the next state so they register on the same
  // edge as the state itself; no combinational path reaches the padring.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_OFF;
      cnt   <= '0;
      poc   <= 1'b1;
      io_en <= 1'b0;
      ready <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      poc   <= !(nxt == S_RELEASE || nxt == S_ACTIVE || nxt == S_DOWN);
      io_en <= (nxt == S_ACTIVE);
      ready <= (nxt == S_ACTIVE);
      fault <= (nxt == S_FAULT);
    end
  end

endmodule
